// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory request/response and decode handshake bundle
interface instr_fetch_unit_if #(parameter int XLEN = 64);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, if_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-owning fetch stage, one outstanding imem read, redirect handling; IFU_MISALIGN_CHECK_EN enables misaligned-redirect halt
module instr_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic [XLEN-1:0]     PCOut,
  output logic                misalign_err
);
`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, HALT} state_t;
  wire [XLEN-1:0] rd_pc = redirect_pc;
`else
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD} state_t;
  wire [XLEN-1:0] rd_pc = redirect_pc & ~XLEN'(3);
`endif
  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n, ifpc_q, ifpc_n;
  logic [31:0]     instr_q, instr_n;
  logic            kill, kill_n, merr, merr_n;
  assign bus.imem_req_valid = (state == FETCH) & ~redirect_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.if_valid       = (state == HOLD);
  assign bus.if_instr       = instr_q;
  assign bus.if_pc          = ifpc_q;
  assign PCOut              = pc;
  assign misalign_err       = merr;
  // next-state, PC and holding-register logic; redirect outranks every handshake
  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    instr_n = instr_q;
    ifpc_n  = ifpc_q;
    merr_n  = merr;
    case (state)
      IDLE: begin
        state_n = FETCH;
        pc_n    = redirect_valid ? rd_pc : pc;
      end
      FETCH:
        if (redirect_valid) pc_n = rd_pc;
        else if (bus.imem_req_ready) begin
          state_n = WAIT;
          ifpc_n  = pc;
        end
      WAIT:
        if (redirect_valid) begin
          pc_n    = rd_pc;
          kill_n  = ~bus.imem_resp_valid;
          state_n = bus.imem_resp_valid ? FETCH : WAIT;
        end else if (bus.imem_resp_valid) begin
          kill_n  = 1'b0;
          state_n = kill ? FETCH : HOLD;
          instr_n = kill ? instr_q : bus.imem_resp_data;
          pc_n    = kill ? pc : pc + PC_STEP;
        end
      HOLD: state_n = (redirect_valid | bus.if_ready) ? FETCH : HOLD;
      default: ;
    endcase
    if (state == HOLD && redirect_valid) pc_n = rd_pc;
`ifdef IFU_MISALIGN_CHECK_EN
    if (state != HALT && redirect_valid && |redirect_pc[1:0]) begin
      merr_n  = 1'b1;
      pc_n    = redirect_pc;
      state_n = HALT;
      kill_n  = 1'b0;
    end
`endif
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      merr    <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      kill    <= kill_n;
      instr_q <= instr_n;
      ifpc_q  <= ifpc_n;
      merr    <= merr_n;
    end
endmodule
